// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch bus master: one outstanding request on an SRAM-like
// bus, buffers the returned word for IF/ID and stalls the PC while busy.
//
// state | meaning
// IDLE  | no transaction; sample pcF when the PC register is valid
// REQ   | inst_req asserted, waiting for inst_addr_ok
// WAIT  | request accepted, waiting for inst_data_ok
// HOLD  | instrF valid for pcF; held while stallF=1
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pcF,
  input  logic              pc_valid,
  input  logic              stallF,
  input  logic              flushF,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic [DATA_W-1:0] instrF,
  output logic              instr_validF,
  output logic              adelF,
  output logic              stall_req
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   pc_lat_q, pc_lat_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                adel_q, adel_d;

  logic                pc_misaligned;

  assign pc_misaligned = (pcF[1:0] != 2'b00);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      pc_lat_q      <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      adel_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      pc_lat_q      <= pc_lat_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      adel_q        <= adel_d;
    end
  end

  // Next-state and register updates; data_ok outside REQ/WAIT is stale and ignored.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    pc_lat_d      = pc_lat_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    adel_d        = adel_q;

    unique case (state_q)
      IDLE: begin
        if (pc_valid && !flushF) begin
          if (!pc_misaligned) begin
            pc_lat_d = pcF;
            state_d  = REQ;
          end else begin
            // AdEL: deliver a nop without touching the bus.
            instr_d       = '0;
            adel_d        = 1'b1;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end

      REQ: begin
        // The request cannot be withdrawn, so a flush only marks the response for discard.
        if (flushF) drop_d = 1'b1;
        if (inst_addr_ok) begin
          state_d = WAIT;
          // Acceptance and response in the same cycle: apply the WAIT response rule now.
          if (inst_data_ok) begin
            if (drop_q || flushF) begin
              drop_d  = 1'b0;
              state_d = IDLE;
            end else begin
              instr_d       = inst_rdata;
              adel_d        = 1'b0;
              instr_valid_d = 1'b1;
              state_d       = HOLD;
            end
          end
        end
      end

      WAIT: begin
        if (inst_data_ok) begin
          if (drop_q || flushF) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            instr_d       = inst_rdata;
            adel_d        = 1'b0;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (flushF) begin
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (flushF || !stallF) begin
          instr_valid_d = 1'b0;
          adel_d        = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Bus and hazard outputs; forced quiet while reset is asserted.
  always_comb begin
    inst_req  = resetn && (state_q == REQ);
    stall_req = resetn && pc_valid && !flushF && (state_q != HOLD) &&
                !((state_q == IDLE) && pc_misaligned);
    if (pc_lat_q[ADDR_W-1:ADDR_W-2] == 2'b10) begin
      inst_addr = {3'b000, pc_lat_q[ADDR_W-4:0]};
    end else begin
      inst_addr = pc_lat_q;
    end
  end

  assign instrF       = instr_q;
  assign instr_validF = instr_valid_q;
  assign adelF        = adel_q;

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch-side bus master directly downstream of the PC register.
- Takes the current fetch PC and issues one request per instruction on the SRAM-like instruction bus (req/addr_ok/data_ok).
- Buffers the returned word for the IF/ID register and stalls the PC while a fetch is in flight.
- On flushF (exception redirect) it drops any in-flight response, and it flags misaligned PCs as AdEL without touching the bus.

Parameters:
- ADDR_W, 32, PC and bus address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  single clock; all state changes on the posedge.
- resetn  in  1  synchronous, active-low reset.
- pcF  in  ADDR_W  current fetch PC from the PC register.
- pc_valid  in  1  PC register has left reset; no fetch is issued while 0.
- stallF  in  1  downstream hazard stall; the fetched word must be held.
- flushF  in  1  exception/eret redirect; the PC reloads this cycle.
- inst_req  out  1  bus request.
- inst_addr  out  ADDR_W  bus address; stable while inst_req=1.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  read data valid.
- inst_rdata  in  DATA_W  read data.
- instrF  out  DATA_W  fetched instruction to IF/ID.
- instr_validF  out  1  instrF holds a valid word for pcF.
- adelF  out  1  instruction address error for the word in instrF.
- stall_req  out  1  to hazard unit; forces PC en=0.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE, drop=0, pc_lat=0, instrF=0, instr_validF=0, adelF=0. inst_req and stall_req are combinational and forced to 0 while resetn=0.
- States: IDLE, REQ, WAIT, HOLD. There is at most one outstanding request.
- IDLE:
  - pc_valid=1, flushF=0, pcF[1:0]=00: pc_lat<=pcF, go to REQ.
  - pc_valid=1, flushF=0, pcF[1:0]!=00: instrF<=0 (nop), adelF<=1, instr_validF<=1, go to HOLD. No bus access.
  - flushF=1 or pc_valid=0: stay in IDLE.
- REQ:
  - inst_req=1, inst_addr=map(pc_lat).
  - A request is never withdrawn; flushF here sets drop<=1.
  - inst_addr_ok=1: go to WAIT.
  - inst_addr_ok and inst_data_ok in the same cycle: treated as acceptance followed by the WAIT response rule in that cycle.
- WAIT:
  - inst_req=0.
  - On inst_data_ok with (drop | flushF): discard, drop<=0, go to IDLE.
  - On inst_data_ok otherwise: instrF<=inst_rdata, adelF<=0, instr_validF<=1, go to HOLD.
  - flushF without data_ok: drop<=1.
- HOLD:
  - instr_validF=1, stall_req=0.
  - flushF=1: instr_validF<=0, adelF<=0, go to IDLE.
  - stallF=1: hold all outputs.
  - stallF=0: the PC advances this cycle; instr_validF<=0, adelF<=0, go to IDLE.
- stall_req = resetn & pc_valid & ~flushF & (state!=HOLD). It is also 0 in IDLE for a misaligned pcF.
- inst_data_ok in IDLE or HOLD (stale, e.g. after reset mid-transaction) is ignored.
- Address map:
  - pc_lat[31:30]=10 (kseg0/kseg1): inst_addr = {3'b000, pc_lat[28:0]}.
  - Otherwise: inst_addr = pc_lat.
- Latency: with addr_ok and data_ok each one cycle after the previous step, the sequence is IDLE→REQ→WAIT→HOLD; instr_validF rises 3 cycles after entering IDLE. The minimum per-instruction period is 4 cycles.
- resetn low in any state aborts the transaction with no bus-side cleanup. Any later stale data_ok is ignored.

Test Plan:
- Basic fetch: reset, pc_valid=1, pcF=0xBFC00000, addr_ok and data_ok one cycle each, rdata=0x3C088000. Expect inst_addr=0x1FC00000, instrF=0x3C088000, instr_validF=1, stall_req=1 until HOLD, then 0.
- Stall hold: stallF=1 for 5 cycles in HOLD. Expect instrF and instr_validF stable and inst_req=0. stallF=0 → IDLE, next request uses the new pcF=0xBFC00004.
- Flush in WAIT: flushF pulse after addr_ok, data_ok 2 cycles later with rdata=0xDEADBEEF. Expect the word discarded, instr_validF never 1, and the next request addr = map(newpc 0xBFC00380)=0x1FC00380.
- Flush coincident with data_ok: flushF=1 and data_ok=1 in the same cycle. Expect discard, IDLE, drop=0.
- Misaligned PC: pcF=0xBFC00002. Expect no inst_req, adelF=1, instrF=0, instr_validF=1, stall_req=0.
- Mid-transaction reset: resetn=0 in WAIT, then stale data_ok after release. Expect the state to stay IDLE, instr_validF=0, and a new request only once pc_valid=1.
